fp_div_fsm_p: RTL and testbench



---
 rtl/fp_div_fsm_p.sv | 191 +++++++++++++++++++
 tb/tb_fp_div_fsm_p.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div_fsm_p.sv
// fp_div_fsm_p: parametrised floating-point divider, res = n / x.
// Restoring mantissa divider (one quotient bit per cycle), round-to-nearest-even,
// IEEE special operands, denormals flushed to zero.
module fp_div_fsm_p #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   r_i,
  input  logic [EXP_W+MAN_W:0]   n,
  input  logic [EXP_W+MAN_W:0]   x,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   r_o,
  output logic                   err,
  output logic                   busy
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int CW = $clog2(MAN_W + 4);
  localparam logic [EXP_W+1:0]        BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [CW-1:0]           LAST = CW'(MAN_W + 2);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_ROUND} state_t;

  state_t                  state_q, state_d;
  logic                    prev_q, busy_q, r_o_q, err_q;
  logic [W-1:0]            n_q, x_q, res_q;
  logic [MAN_W:0]          mb_q;
  logic [MAN_W+1:0]        rem_q;
  logic [MAN_W+2:0]        q_q;
  logic [CW-1:0]           cnt_q;
  logic signed [EXP_W+1:0] e_q;
  logic                    sign_q, guard_q, sticky_q;
  logic [MAN_W-1:0]        frac_q;
  logic                    spec_q, serr_q;
  logic [W-1:0]            sres_q;

  logic [EXP_W-1:0] en, ex;
  logic [MAN_W-1:0] mn, mx;
  logic             n_zero, x_zero, n_inf, x_inf, n_nan, x_nan, sgn, start;
  logic             spec_d, serr_d;
  logic [W-1:0]     sres_d;
  logic             div_ge;
  logic [MAN_W+1:0] div_diff, div_t;
  logic             inc;
  logic [MAN_W:0]   sum;
  logic signed [EXP_W+1:0] e_r;
  logic [W-1:0]     rnd_res;
  logic             rnd_err;

  assign en     = n_q[W-2:MAN_W];
  assign ex     = x_q[W-2:MAN_W];
  assign mn     = n_q[MAN_W-1:0];
  assign mx     = x_q[MAN_W-1:0];
  assign n_zero = (en == '0);
  assign x_zero = (ex == '0);
  assign n_inf  = (&en) && (mn == '0);
  assign x_inf  = (&ex) && (mx == '0);
  assign n_nan  = (&en) && (mn != '0);
  assign x_nan  = (&ex) && (mx != '0);
  assign sgn    = n_q[W-1] ^ x_q[W-1];
  assign start  = (state_q == S_IDLE) && !busy_q && r_i && !prev_q;

  assign res  = res_q;
  assign r_o  = r_o_q;
  assign err  = err_q;
  assign busy = busy_q;

  // Special-operand classification of the latched operands.
  always_comb begin
    spec_d = 1'b1;
    sres_d = '0;
    serr_d = 1'b0;
    if (n_nan || x_nan || (n_zero && x_zero) || (n_inf && x_inf)) begin
      sres_d = QNAN;
      serr_d = 1'b1;
    end else if (n_inf) begin
      sres_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (x_inf) begin
      sres_d = {sgn, {(W-1){1'b0}}};
    end else if (x_zero) begin
      sres_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      serr_d = 1'b1;
    end else if (n_zero) begin
      sres_d = {sgn, {(W-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  // One restoring-division step; remainder is shifted for the next trial.
  always_comb begin
    div_diff = rem_q - {1'b0, mb_q};
    div_ge   = (rem_q >= {1'b0, mb_q});
    div_t    = div_ge ? div_diff : rem_q;
  end

  // RNE rounding, exponent range check and result packing.
  always_comb begin
    inc     = guard_q & (sticky_q | frac_q[0]);
    sum     = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc};
    e_r     = e_q + {{(EXP_W+1){1'b0}}, sum[MAN_W]};
    rnd_res = {sign_q, e_r[EXP_W-1:0], sum[MAN_W-1:0]};
    rnd_err = 1'b0;
    if (e_r >= EMAX) begin
      rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_err = 1'b1;
    end else if (e_r <= 0) begin
      rnd_res = {sign_q, {(W-1){1'b0}}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      S_UNPACK: state_d = spec_d ? S_ROUND : S_DIVIDE;
      S_DIVIDE: if (cnt_q == LAST) state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  // busy_q stays high through the r_o cycle, so the IDLE state visible during
  // r_o cannot accept a start; the next IDLE cycle can.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;  busy_q <= 1'b0;  r_o_q <= 1'b0;  err_q <= 1'b0;
      res_q  <= '0;    n_q    <= '0;    x_q   <= '0;    mb_q  <= '0;
      rem_q  <= '0;    q_q    <= '0;    cnt_q <= '0;    e_q   <= '0;
      sign_q <= 1'b0;  guard_q <= 1'b0; sticky_q <= 1'b0; frac_q <= '0;
      spec_q <= 1'b0;  serr_q <= 1'b0;  sres_q <= '0;
    end else begin
      prev_q <= r_i;
      r_o_q  <= 1'b0;
      if (r_o_q) busy_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          n_q    <= n;
          x_q    <= x;
          busy_q <= 1'b1;
        end
        S_UNPACK: begin
          spec_q <= spec_d;
          sres_q <= sres_d;
          serr_q <= serr_d;
          sign_q <= sgn;
          rem_q  <= {1'b0, 1'b1, mn};
          mb_q   <= {1'b1, mx};
          q_q    <= '0;
          cnt_q  <= '0;
          e_q    <= {2'b00, en} - {2'b00, ex} + BIAS;
        end
        S_DIVIDE: begin
          q_q   <= {q_q[MAN_W+1:0], div_ge};
          rem_q <= div_t << 1;
          cnt_q <= cnt_q + CW'(1);
        end
        S_NORM: begin
          if (q_q[MAN_W+2]) begin
            frac_q   <= q_q[MAN_W+1:2];
            guard_q  <= q_q[1];
            sticky_q <= q_q[0] | (rem_q != '0);
          end else begin
            frac_q   <= q_q[MAN_W:1];
            guard_q  <= q_q[0];
            sticky_q <= (rem_q != '0);
            e_q      <= e_q - {{(EXP_W+1){1'b0}}, 1'b1};
          end
        end
        S_ROUND: begin
          res_q <= spec_q ? sres_q : rnd_res;
          err_q <= spec_q ? serr_q : rnd_err;
          r_o_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_fsm_p.sv
// Scoreboard bench for fp_div_fsm_p: single-precision and EXP_W=5/MAN_W=10 instances.
module tb_fp_div_fsm_p;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rA = 1'b1, rB = 1'b0;
  logic [31:0] nA = '0, xA = '0, resA;
  logic [15:0] nB = '0, xB = '0, resB;
  logic        r_oA, errA, busyA, r_oB, errB, busyB;
  int          cyc = 0;
  int          n_vec = 0, n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sbA[$];
  exp_t sbB[$];

  fp_div_fsm_p dutA (
    .clk(clk), .rst(rst), .r_i(rA), .n(nA), .x(xA),
    .res(resA), .r_o(r_oA), .err(errA), .busy(busyA)
  );

  fp_div_fsm_p #(.EXP_W(5), .MAN_W(10)) dutB (
    .clk(clk), .rst(rst), .r_i(rB), .n(nB), .x(xB),
    .res(resB), .r_o(r_oB), .err(errB), .busy(busyB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Result monitors: pop the expected entry on every r_o pulse.
  always @(negedge clk) if (r_oA) begin
    if (sbA.size() == 0) chk("A spurious r_o", 32'd1, 32'd0);
    else begin
      exp_t e;
      e = sbA.pop_front();
      chk("A res", resA, e.res);
      chk("A err", {31'd0, errA}, {31'd0, e.err});
      chk("A latency", 32'(cyc - e.t0), 32'(e.lat));
      chk("A busy@r_o", {31'd0, busyA}, 32'd1);
    end
  end

  always @(negedge clk) if (r_oB) begin
    if (sbB.size() == 0) chk("B spurious r_o", 32'd1, 32'd0);
    else begin
      exp_t e;
      e = sbB.pop_front();
      chk("B res", {16'd0, resB}, e.res);
      chk("B err", {31'd0, errB}, {31'd0, e.err});
      chk("B latency", 32'(cyc - e.t0), 32'(e.lat));
    end
  end

  task automatic waitA();
    for (int i = 0; i < 200; i++) begin
      if (!busyA && sbA.size() == 0) return;
      @(negedge clk);
    end
    chk("A timeout", 32'd0, 32'd1);
    sbA.delete();
  endtask

  task automatic waitB();
    for (int i = 0; i < 200; i++) begin
      if (!busyB && sbB.size() == 0) return;
      @(negedge clk);
    end
    chk("B timeout", 32'd0, 32'd1);
    sbB.delete();
  endtask

  task automatic pushA(input logic [31:0] er, input logic ee, input int lat);
    exp_t e;
    e.res = er; e.err = ee; e.lat = lat; e.t0 = cyc + 1;
    sbA.push_back(e);
  endtask

  task automatic opA(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                     input logic ee, input int lat, input int hold);
    @(negedge clk);
    nA = a; xA = b; rA = 1'b1;
    pushA(er, ee, lat);
    repeat (hold) @(negedge clk);
    rA = 1'b0;
    waitA();
  endtask

  task automatic opB(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                     input logic ee, input int lat);
    exp_t e;
    @(negedge clk);
    nB = a; xB = b; rB = 1'b1;
    e.res = {16'd0, er}; e.err = ee; e.lat = lat; e.t0 = cyc + 1;
    sbB.push_back(e);
    @(negedge clk);
    rB = 1'b0;
    waitB();
  endtask

  initial begin
    // Reset with r_i held high: must not start afterwards.
    repeat (3) @(negedge clk);
    chk("rst res", resA, 32'd0);
    chk("rst err", {31'd0, errA}, 32'd0);
    chk("rst r_o", {31'd0, r_oA}, 32'd0);
    chk("rst busy", {31'd0, busyA}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("held r_i after rst", {31'd0, busyA}, 32'd0);
    rA = 1'b0;
    @(negedge clk);

    opA(32'h40A00000, 32'h40E00000, 32'h3F36DB6E, 1'b0, 29, 2);   // 5/7
    opA(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, 1);   // 6/2
    opA(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 29, 1);   // -6/2
    opA(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 29, 1);   // 1/3 rounds up
    opA(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 29, 1);   // 1/1
    opA(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2, 1);    // -1/0
    opA(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 2, 1);    // 0/0
    opA(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 2, 1);    // inf/2
    opA(32'h40400000, 32'h7F800000, 32'h00000000, 1'b0, 2, 1);    // 3/inf
    opA(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 2, 1);    // NaN/1
    opA(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 29, 1);   // overflow
    opA(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 29, 1);   // underflow

    // r_i held across completion: single r_o, no restart.
    opA(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, 40);
    repeat (3) @(negedge clk);
    chk("held r_i no restart", {31'd0, busyA}, 32'd0);

    // r_i pulse mid-DIVIDE is ignored; res holds the previous result meanwhile.
    @(negedge clk);
    nA = 32'h40A00000; xA = 32'h40E00000; rA = 1'b1;
    pushA(32'h3F36DB6E, 1'b0, 29);
    @(negedge clk); rA = 1'b0;
    repeat (8) @(negedge clk);
    nA = 32'h3F800000; xA = 32'h3F800000; rA = 1'b1;
    @(negedge clk); rA = 1'b0;
    repeat (5) @(negedge clk);
    chk("res held mid-op", resA, 32'h40400000);
    waitA();
    repeat (3) @(negedge clk);
    chk("pulse no restart", {31'd0, busyA}, 32'd0);

    // Reset 10 cycles into a divide: no r_o, outputs at reset values.
    @(negedge clk);
    nA = 32'h40C00000; xA = 32'h40000000; rA = 1'b1;
    @(negedge clk); rA = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort res", resA, 32'd0);
    chk("abort err", {31'd0, errA}, 32'd0);
    chk("abort busy", {31'd0, busyA}, 32'd0);
    chk("abort r_o", {31'd0, r_oA}, 32'd0);
    repeat (40) @(negedge clk);
    opA(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, 1);

    // Half-precision-like instance.
    opB(16'h4500, 16'h4700, 16'h39B7, 1'b0, 16);
    opB(16'h4200, 16'h4000, 16'h3E00, 1'b0, 16);
    opB(16'h3C00, 16'h0000, 16'h7C00, 1'b1, 2);
    opB(16'h0000, 16'h0000, 16'h7E00, 1'b1, 2);

    repeat (3) @(negedge clk);
    chk("A queue drained", 32'(sbA.size()), 32'd0);
    chk("B queue drained", 32'(sbB.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
